// File: rtl/ipf_pkg.sv
// Shared command codes, FSM state encoding and accumulator sizing for the IPF conv engine.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package ipf_pkg;

   localparam logic [1:0] CTRL_NOP    = 2'd0;
   localparam logic [1:0] CTRL_LOAD_W = 2'd1;
   localparam logic [1:0] CTRL_RUN    = 2'd2;
   localparam logic [1:0] CTRL_END    = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Exact width of a TAPS-term sum of unsigned-pixel x signed-weight products.
   function automatic int acc_w(input int in_w, input int w_w, input int taps);
      return in_w + w_w + 1 + $clog2(taps);
   endfunction

endpackage

// File: rtl/ipf_mac_lane.sv
// One lane: TAPS-deep pixel window, registered products (stage1), registered sum/format (stage2).
// Latency: products load on the accepting edge, result loads one edge later.
// Backpressure: none; narrowing saturates when IPF_SAT_EN is defined, otherwise wraps.
module ipf_mac_lane
   import ipf_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int W_W   = 4,
   parameter int OUT_W = 16,
   parameter int TAPS  = 3
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          shift_en,
   input  logic                          sum_en,
   input  logic [IN_W-1:0]               pix,
   input  logic [TAPS-1:0][W_W-1:0]      w,
   output logic [OUT_W-1:0]              res
);

   localparam int P_W   = IN_W + W_W + 1;
   localparam int ACC_W = acc_w(IN_W, W_W, TAPS);
   localparam int EXT_W = ACC_W - P_W;

   logic [TAPS-1:0][IN_W-1:0] win_q, win_d;   // win_q[0] is the newest pixel
   logic [TAPS-1:0][P_W-1:0]  prod_q, prod_d;
   logic [ACC_W-1:0]          acc;
   logic [OUT_W-1:0]          fmt;
   logic [OUT_W-1:0]          res_q, res_d;

   // Window shift and stage1 products, computed from the window as it will be after this beat.
   always_comb begin
      win_d  = win_q;
      prod_d = prod_q;
      if (shift_en) begin
         win_d[0] = pix;
         for (int k = 1; k < TAPS; k++) begin
            win_d[k] = win_q[k-1];
         end
         // Both operands extended to P_W; the low P_W bits of the product are exact.
         for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = {{W_W{1'b0}}, 1'b0, win_d[k]} * {{(P_W-W_W){w[k][W_W-1]}}, w[k]};
         end
      end
   end

   // Stage2 adder over sign-extended products.
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         acc = acc + {{EXT_W{prod_q[k][P_W-1]}}, prod_q[k]};
      end
   end

   generate
      if (OUT_W > ACC_W) begin : g_ext
         assign fmt = {{(OUT_W-ACC_W){acc[ACC_W-1]}}, acc};
      end else if (OUT_W == ACC_W) begin : g_same
         assign fmt = acc;
      end else begin : g_narrow
`ifdef IPF_SAT_EN
         logic ovf;
         // Overflow when the discarded bits are not all copies of the kept sign bit.
         assign ovf = (acc[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc[ACC_W-1]}});
         assign fmt = !ovf           ? acc[OUT_W-1:0] :
                      acc[ACC_W-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                                       {1'b0, {(OUT_W-1){1'b1}}};
`else
         logic unused_hi;
         assign unused_hi = ^acc[ACC_W-1:OUT_W];
         assign fmt = acc[OUT_W-1:0];
`endif
      end
   endgenerate

   // Result register holds its last value between valid results.
   always_comb begin
      res_d = sum_en ? fmt : res_q;
   end

   // Window, product and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q  <= '0;
         prod_q <= '0;
         res_q  <= '0;
      end else begin
         win_q  <= win_d;
         prod_q <= prod_d;
         res_q  <= res_d;
      end
   end

   assign res = res_q;

endmodule

// File: rtl/ipf_conv_engine.sv
// Multi-lane sliding-window MAC: shared signed weights, LANES unsigned pixel streams, one result per lane per beat.
// Latency: res_valid two cycles after the accepting beat; first result on the TAPS-th beat of a RUN.
// Backpressure: none, every beat in RUN is accepted; IPF_SAT_EN selects saturating narrowing.
module ipf_conv_engine
   import ipf_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int W_W   = 4,
   parameter int OUT_W = 16,
   parameter int TAPS  = 3,
   parameter int LANES = 4,
   parameter int A_W   = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             ctrl,
   input  logic                   i_valid,
   input  logic [LANES*IN_W-1:0]  i_data,
   input  logic                   w_valid,
   input  logic [W_W-1:0]         w_data,
   output logic                   res_valid,
   output logic [LANES*OUT_W-1:0] res,
   output logic [A_W-1:0]         res_cnt,
   output logic                   finish
);

   localparam int              IDX_W = $clog2(TAPS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(TAPS-1);

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          widx_q, widx_d;
   logic                      w_loaded_q, w_loaded_d;
   logic [TAPS-1:0][W_W-1:0]  w_q, w_d;
   logic [IDX_W-1:0]          fill_q, fill_d;
   logic                      drn_q, drn_d;
   logic                      s1_vld_q, s1_vld_d;
   logic                      res_valid_q, res_valid_d;
   logic [A_W-1:0]            res_cnt_q, res_cnt_d;
   logic                      accept;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; DONE reacts to commands exactly like IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (ctrl == CTRL_LOAD_W) begin
               state_d = ST_LOAD_W;
            end else if (ctrl == CTRL_RUN && w_loaded_q) begin
               state_d = ST_RUN;
            end
         end
         ST_LOAD_W: if (w_valid && widx_q == LAST) state_d = ST_IDLE;
         ST_RUN:    if (ctrl == CTRL_END) state_d = ST_DRAIN;
         ST_DRAIN:  if (drn_q) state_d = ST_DONE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: beat acceptance, stage1 valid (window full) and finish flag.
   always_comb begin
      accept    = (state_q == ST_RUN) && i_valid;
      s1_vld_d  = accept && (fill_q == LAST);
      finish    = (state_q == ST_DONE);
   end

   // Weight loading, window fill count, drain timer and result counter.
   always_comb begin
      widx_d      = widx_q;
      w_loaded_d  = w_loaded_q;
      w_d         = w_q;
      fill_d      = fill_q;
      drn_d       = 1'b0;
      res_valid_d = s1_vld_q;
      res_cnt_d   = s1_vld_q ? res_cnt_q + A_W'(1) : res_cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (ctrl == CTRL_LOAD_W) begin
               widx_d     = '0;
               w_loaded_d = 1'b0;   // stays clear if the load is abandoned part-way
            end else if (ctrl == CTRL_RUN && w_loaded_q) begin
               fill_d    = '0;
               res_cnt_d = '0;
            end
         end
         ST_LOAD_W: begin
            if (w_valid) begin
               w_d[widx_q] = w_data;
               widx_d      = widx_q + IDX_W'(1);
               if (widx_q == LAST) w_loaded_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (accept && fill_q != LAST) fill_d = fill_q + IDX_W'(1);
         end
         ST_DRAIN: drn_d = !drn_q;
         default: ;
      endcase
   end

   // Control and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         widx_q      <= '0;
         w_loaded_q  <= 1'b0;
         w_q         <= '0;
         fill_q      <= '0;
         drn_q       <= 1'b0;
         s1_vld_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_cnt_q   <= '0;
      end else begin
         widx_q      <= widx_d;
         w_loaded_q  <= w_loaded_d;
         w_q         <= w_d;
         fill_q      <= fill_d;
         drn_q       <= drn_d;
         s1_vld_q    <= s1_vld_d;
         res_valid_q <= res_valid_d;
         res_cnt_q   <= res_cnt_d;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      ipf_mac_lane #(
         .IN_W  (IN_W),
         .W_W   (W_W),
         .OUT_W (OUT_W),
         .TAPS  (TAPS)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .shift_en (accept),
         .sum_en   (s1_vld_q),
         .pix      (i_data[l*IN_W +: IN_W]),
         .w        (w_q),
         .res      (res[l*OUT_W +: OUT_W])
      );
   end

   assign res_valid = res_valid_q;
   assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_ipf_conv_engine.sv
// Directed bench for ipf_conv_engine: per-cycle vector table plus hand sequences.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; a second instance with OUT_W=12 covers narrowing.
module tb_ipf_conv_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ctrl;
   logic        i_valid;
   logic [31:0] i_data;
   logic        w_valid;
   logic [3:0]  w_data;

   logic        res_valid,   res_valid12;
   logic [63:0] res;
   logic [47:0] res12;
   logic [15:0] res_cnt,     res_cnt12;
   logic        finish,      finish12;

   always #5 clk = ~clk;

   ipf_conv_engine dut (
      .clk(clk), .rst(rst), .ctrl(ctrl), .i_valid(i_valid), .i_data(i_data),
      .w_valid(w_valid), .w_data(w_data), .res_valid(res_valid), .res(res),
      .res_cnt(res_cnt), .finish(finish)
   );

   ipf_conv_engine #(.OUT_W(12)) dut12 (
      .clk(clk), .rst(rst), .ctrl(ctrl), .i_valid(i_valid), .i_data(i_data),
      .w_valid(w_valid), .w_data(w_data), .res_valid(res_valid12), .res(res12),
      .res_cnt(res_cnt12), .finish(finish12)
   );

   typedef struct {
      logic [1:0]  ctrl;
      logic        iv;
      logic [31:0] idat;
      logic        wv;
      logic [3:0]  wdat;
      logic        erv;
      logic [63:0] eres;
      logic [15:0] ecnt;
      logic        efin;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Lane l carries pixel p+l.
   function automatic logic [31:0] mk_pix(input int p);
      return {8'(p + 3), 8'(p + 2), 8'(p + 1), 8'(p)};
   endfunction

   // With weights {1,-2,3} (sum 2), lane l result is y + 2*l.
   function automatic logic [63:0] mk_res(input int y);
      return {16'(y + 6), 16'(y + 4), 16'(y + 2), 16'(y)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] c, input logic iv, input logic [31:0] id,
                       input logic wv, input logic [3:0] wd);
      ctrl = c; i_valid = iv; i_data = id; w_valid = wv; w_data = wd;
      @(posedge clk);
      #1;
   endtask

   // ey < 0 means res is still all-zero from reset.
   task automatic row(input logic [1:0] c, input logic iv, input int p, input logic wv,
                      input logic [3:0] wd, input logic erv, input int ey, input int ecnt,
                      input logic efin);
      vec_t v;
      v.ctrl = c; v.iv = iv; v.idat = iv ? mk_pix(p) : 32'd0; v.wv = wv; v.wdat = wd;
      v.erv = erv; v.eres = (ey < 0) ? 64'd0 : mk_res(ey); v.ecnt = 16'(ecnt); v.efin = efin;
      tbl.push_back(v);
   endtask

   logic [11:0] exp12;

   initial begin
      rst = 1'b1; ctrl = 2'd0; i_valid = 1'b0; i_data = '0; w_valid = 1'b0; w_data = '0;
`ifdef IPF_SAT_EN
      exp12 = 12'h800;
`else
      exp12 = 12'h818;
`endif

      // No weights loaded: RUN refused, pixels and END ignored.
      row(2, 0, 0,  0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 7,  0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 8,  0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 9,  0, 4'h0, 0, -1, 0, 0);
      row(3, 0, 0,  0, 4'h0, 0, -1, 0, 0);
      row(0, 0, 0,  0, 4'h0, 0, -1, 0, 0);
      // Load w = {1,-2,3}.
      row(1, 0, 0,  0, 4'h0, 0, -1, 0, 0);
      row(0, 0, 0,  1, 4'h1, 0, -1, 0, 0);
      row(0, 0, 0,  1, 4'hE, 0, -1, 0, 0);
      row(0, 0, 0,  1, 4'h3, 0, -1, 0, 0);
      // RUN with 10,20,30,40: results 20 then 40.
      row(2, 0, 0,  0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 10, 0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 20, 0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 30, 0, 4'h0, 0, -1, 0, 0);
      row(0, 1, 40, 0, 4'h0, 1, 20, 1, 0);
      row(3, 0, 0,  0, 4'h0, 1, 40, 2, 0);
      row(0, 0, 0,  0, 4'h0, 0, 40, 2, 0);
      row(0, 0, 0,  0, 4'h0, 0, 40, 2, 1);
      row(0, 0, 0,  0, 4'h0, 0, 40, 2, 1);
      // Second RUN without reload; END arrives with the third beat.
      row(2, 0, 0,  0, 4'h0, 0, 40, 0, 0);
      row(0, 1, 1,  0, 4'h0, 0, 40, 0, 0);
      row(0, 1, 2,  0, 4'h0, 0, 40, 0, 0);
      row(3, 1, 3,  0, 4'h0, 0, 40, 0, 0);
      row(0, 0, 0,  0, 4'h0, 1, 2,  1, 0);
      row(0, 0, 0,  0, 4'h0, 0, 2,  1, 1);

      // Reset state.
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("reset res_valid", res_valid, 0);
      check("reset res", res, 0);
      check("reset res_cnt", res_cnt, 0);
      check("reset finish", finish, 0);
      check("reset res12", res12, 0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].ctrl, tbl[i].iv, tbl[i].idat, tbl[i].wv, tbl[i].wdat);
         check($sformatf("row%0d res_valid", i), res_valid, tbl[i].erv);
         check($sformatf("row%0d res", i), res, tbl[i].eres);
         check($sformatf("row%0d res_cnt", i), res_cnt, tbl[i].ecnt);
         check($sformatf("row%0d finish", i), finish, tbl[i].efin);
      end

      // Narrowing: weights all -8, pixels 255 -> -6120.
      step(2'd1, 0, '0, 0, 4'h0);
      for (int k = 0; k < 3; k++) step(2'd0, 0, '0, 1, 4'h8);
      step(2'd2, 0, '0, 0, 4'h0);
      for (int k = 0; k < 3; k++) step(2'd0, 1, 32'hFFFF_FFFF, 0, 4'h0);
      step(2'd0, 0, '0, 0, 4'h0);
      check("sat res_valid", res_valid, 1);
      check("sat res 16b", res, {4{16'hE818}});
      check("sat res_cnt", res_cnt, 1);
      check("sat res_valid12", res_valid12, 1);
      check("sat res 12b", res12, {4{exp12}});
      check("sat res_cnt12", res_cnt12, 1);

      // Reset mid-RUN with a full window and a beat in flight.
      step(2'd0, 1, 32'hFFFF_FFFF, 0, 4'h0);
      rst = 1'b1;
      step(2'd0, 1, 32'hFFFF_FFFF, 0, 4'h0);
      check("rst res_valid", res_valid, 0);
      check("rst res", res, 0);
      check("rst res_cnt", res_cnt, 0);
      check("rst finish", finish, 0);
      check("rst finish12", finish12, 0);
      rst = 1'b0;
      // Weights were cleared: RUN is refused, so no beat may produce a result.
      step(2'd2, 0, '0, 0, 4'h0);
      for (int k = 0; k < 6; k++) begin
         step(2'd0, (k < 4), mk_pix(50 + k), 0, 4'h0);
         check($sformatf("post-rst beat%0d res_valid", k), res_valid, 0);
      end
      check("post-rst res", res, 0);
      check("post-rst finish", finish, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
